// File: rtl/spi_readback_tx_if.sv
// SPI readback transmitter bus: chip select, serial data and register-bank read port.
// The bank (or the bench) is the master side; spi_readback_tx is the slave side.
interface spi_readback_tx_if;
    logic       _CS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] ReadData;
    logic [7:0] ReadAddress;
    logic       ReadStrobe;
    logic       Busy;

    modport master (
        output _CS,
        output MOSI,
        output ReadData,
        input  MISO,
        input  ReadAddress,
        input  ReadStrobe,
        input  Busy
    );

    modport slave (
        input  _CS,
        input  MOSI,
        input  ReadData,
        output MISO,
        output ReadAddress,
        output ReadStrobe,
        output Busy
    );
endinterface

// File: rtl/spi_readback_tx.sv
// SPI mode-0 readback transmitter: decodes the command byte, streams register bytes on MISO.
// Optional SPI_TX_TRISTATE_EN: MISO floats when deselected or not reading.
module spi_readback_tx #(
    parameter int MaxAddress  = 23,
    parameter int ReadFlagBit = 7
) (
    input  logic SCLK,
    input  logic _RST,
    spi_readback_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        READ,
        IGNORE
    } state_t;

    localparam logic [7:0] MAX_ADDR = 8'(MaxAddress);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] cmd_q, cmd_d;
    logic [7:0] cmd_byte;
    logic [7:0] addr_q;
    logic [7:0] tx_q;
    logic       strobe_q, strobe_d;
    logic       ld_addr, inc_addr;
    logic       cs_n;

    assign cs_n     = bus._CS;
    assign cmd_byte = {cmd_q, bus.MOSI};

    // _CS high acts as an asynchronous abort for everything but the address.
    always_ff @(posedge SCLK or negedge _RST or posedge cs_n) begin
        if (!_RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            strobe_q <= 1'b0;
        end else if (cs_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 3'd1;
        cmd_d    = cmd_q;
        strobe_d = 1'b0;
        ld_addr  = 1'b0;
        inc_addr = 1'b0;
        unique case (state_q)
            IDLE, CMD: begin
                cmd_d   = cmd_byte[6:0];
                state_d = CMD;
                if (cnt_q == 3'd7) begin
                    if (cmd_byte[ReadFlagBit] &&
                        ({1'b0, cmd_byte[6:0]} <= MAX_ADDR)) begin
                        state_d  = READ;
                        ld_addr  = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            READ: begin
                if (cnt_q == 3'd7) begin
                    inc_addr = 1'b1;
                    strobe_d = 1'b1;
                end
            end
            IGNORE: begin
                state_d = IGNORE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address survives an abort; only reset clears it.
    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            addr_q <= '0;
        end else if (!cs_n) begin
            if (ld_addr) begin
                addr_q <= {1'b0, cmd_byte[6:0]};
            end else if (inc_addr) begin
                addr_q <= (addr_q == MAX_ADDR) ? 8'd0 : addr_q + 8'd1;
            end
        end
    end

    // Bit counter at 0 in READ marks the falling edge right after a byte boundary.
    always_ff @(negedge SCLK or negedge _RST or posedge cs_n) begin
        if (!_RST) begin
            tx_q <= '0;
        end else if (cs_n) begin
            tx_q <= '0;
        end else if (state_q == READ && cnt_q == 3'd0) begin
            tx_q <= bus.ReadData;
        end else begin
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

`ifdef SPI_TX_TRISTATE_EN
    assign bus.MISO = (cs_n || state_q != READ) ? 1'bz : tx_q[7];
`else
    assign bus.MISO = (state_q == READ) ? tx_q[7] : 1'b0;
`endif

    assign bus.ReadAddress = addr_q;
    assign bus.ReadStrobe  = strobe_q;
    assign bus.Busy        = (state_q == READ);
endmodule
